// File: rtl/stream_demux2.sv
// stream_demux2: 1-to-2 valid/ready demux routing each accepted word by in_sel into a per-branch FIFO.
module stream_demux2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [WIDTH-1:0]         a_data,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [WIDTH-1:0]         b_data,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic [$clog2(DEPTH):0]   b_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]       w_full;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_take;
    logic [WIDTH-1:0] w_head [2];
    logic [CW-1:0]    w_cnt  [2];

    // in_ready depends only on in_sel and registered fullness, so a full branch never blocks the other
    assign in_ready = in_sel ? !w_full[1] : !w_full[0];
    assign w_push   = {in_valid && in_ready && in_sel, in_valid && in_ready && !in_sel};
    assign w_take   = {b_ready, a_ready};

    for (genvar g = 0; g < 2; g++) begin : g_br
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_rd;
        logic [AW-1:0]    r_wr;
        logic [CW-1:0]    r_cnt;

        assign w_full[g] = r_cnt == CW'(DEPTH);
        assign w_pop[g]  = (r_cnt != '0) && w_take[g];
        assign w_head[g] = r_mem[r_rd];
        assign w_cnt[g]  = r_cnt;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            end else begin
                if (w_push[g]) begin
                    r_mem[r_wr] <= in_data;
                    r_wr        <= r_wr + AW'(1);
                end
                if (w_pop[g]) r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + CW'(w_push[g]) - CW'(w_pop[g]);
            end
        end
    end

    assign a_valid = w_cnt[0] != '0;
    assign b_valid = w_cnt[1] != '0;
    assign a_data  = w_head[0];
    assign b_data  = w_head[1];
    assign a_count = w_cnt[0];
    assign b_count = w_cnt[1];
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: directed plus random stimulus checked against a queue-based model of two FIFOs.
module tb_stream_demux2;
    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sel = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          a_ready = 1'b0;
    logic          b_ready = 1'b0;
    logic          in_ready, a_valid, b_valid;
    logic [W-1:0]  a_data, b_data;
    logic [CW-1:0] a_count, b_count;

    int total = 0;
    int bad = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    stream_demux2 #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_check(input string tag);
        int na = qa.size();
        int nb = qb.size();
        chk({tag, "_a_valid"}, 32'(a_valid), 32'(na != 0));
        chk({tag, "_b_valid"}, 32'(b_valid), 32'(nb != 0));
        chk({tag, "_a_count"}, 32'(a_count), 32'(na));
        chk({tag, "_b_count"}, 32'(b_count), 32'(nb));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(in_sel ? nb < D : na < D));
        if (na != 0) chk({tag, "_a_data"}, a_data, qa[0]);
        if (nb != 0) chk({tag, "_b_data"}, b_data, qb[0]);
    endtask

    // inputs are set by the caller at edge+1; checks run at edge+2, the model advances after the edge
    task automatic cycle(input string tag);
        bit acc, pa, pb, sel;
        logic [W-1:0] d;
        #1;
        model_check(tag);
        sel = in_sel;
        d   = in_data;
        acc = in_valid && (sel ? qb.size() < D : qa.size() < D);
        pa  = qa.size() != 0 && a_ready;
        pb  = qb.size() != 0 && b_ready;
        @(posedge clk);
        #1;
        if (!resetn) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (acc) begin
                if (sel) qb.push_back(d);
                else qa.push_back(d);
            end
        end
    endtask

    initial begin
        #3;
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_b_valid", 32'(b_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_a_data", a_data, 0);
        #9 resetn = 1'b1;

        // single route
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
        cycle("t2_push");
        in_valid = 1'b0;
        #1;
        chk("t2_a_valid", 32'(a_valid), 1);
        chk("t2_a_data", a_data, 32'hDEADBEEF);
        chk("t2_b_valid", 32'(b_valid), 0);
        chk("t2_a_count", 32'(a_count), 1);

        // fill A, B stays reachable, then drain A in order
        a_ready = 1'b1;
        cycle("t3_drain0");
        a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        cycle("t3_p11");
        in_data = 32'h22;
        cycle("t3_p22");
        in_valid = 1'b0;
        #1;
        chk("t3_a_count", 32'(a_count), 2);
        chk("t3_ready_a_full", 32'(in_ready), 0);
        in_sel = 1'b1;
        #1;
        chk("t3_ready_b", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = 32'h33;
        cycle("t3_p33");
        in_valid = 1'b0;
        #1;
        chk("t3_b_data", b_data, 32'h33);
        a_ready = 1'b1;
        #1;
        chk("t3_a_first", a_data, 32'h11);
        cycle("t3_pop11");
        #1;
        chk("t3_a_second", a_data, 32'h22);
        cycle("t3_pop22");
        a_ready = 1'b0; b_ready = 1'b1;
        cycle("t3_pop33");
        b_ready = 1'b0;

        // simultaneous push/pop with A holding one entry
        in_sel = 1'b0; a_ready = 1'b1; in_valid = 1'b1; in_data = 32'd0;
        cycle("t4_seed");
        for (int i = 1; i <= 10; i++) begin
            in_data = 32'(i);
            cycle("t4_pp");
            #1;
            chk("t4_a_count", 32'(a_count), 1);
            chk("t4_a_data", a_data, 32'(i));
        end
        in_valid = 1'b0;
        cycle("t4_drain");
        a_ready = 1'b0;

        // interleave across branches with both consumers ready
        a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
        in_sel = 1'b0; in_data = 32'hA0;
        cycle("t5_a0");
        #1 chk("t5_a0_out", a_data, 32'hA0);
        in_sel = 1'b1; in_data = 32'hB0;
        cycle("t5_b0");
        #1 chk("t5_b0_out", b_data, 32'hB0);
        in_sel = 1'b0; in_data = 32'hA1;
        cycle("t5_a1");
        #1 chk("t5_a1_out", a_data, 32'hA1);
        in_sel = 1'b1; in_data = 32'hB1;
        cycle("t5_b1");
        #1 chk("t5_b1_out", b_data, 32'hB1);
        in_valid = 1'b0;
        cycle("t5_drain");

        // backpressure hold on B
        b_ready = 1'b0; in_sel = 1'b1; in_valid = 1'b1; in_data = 32'hC6;
        cycle("t6_push");
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("t6_hold");
            #1;
            chk("t6_b_data", b_data, 32'hC6);
            chk("t6_b_count", 32'(b_count), 1);
        end
        b_ready = 1'b1;
        cycle("t6_release");
        b_ready = 1'b0;

        // asynchronous reset with two words in A
        a_ready = 1'b0; in_sel = 1'b0; in_valid = 1'b1; in_data = 32'h51;
        cycle("t1_p1");
        in_data = 32'h52;
        cycle("t1_p2");
        in_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("t1_a_valid", 32'(a_valid), 0);
        chk("t1_b_valid", 32'(b_valid), 0);
        chk("t1_a_count", 32'(a_count), 0);
        chk("t1_a_data", a_data, 0);
        chk("t1_in_ready", 32'(in_ready), 1);
        qa.delete();
        qb.delete();
        cycle("t1_in_reset");
        resetn = 1'b1;
        cycle("t1_release");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            a_ready  = $urandom_range(0, 9) < 6;
            b_ready  = $urandom_range(0, 9) < 4;
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- Parameterised 1-to-2 stream demultiplexer; the distributing counterpart of the two-input select mux used in the datapath.
- Accepts one valid/ready input stream tagged with a select bit.
- Routes each accepted word into a small per-branch FIFO, and presents each FIFO on its own valid/ready output port.
- Typical use: splitting a shared bus/memory response stream between the instruction-side consumer (branch A) and the data-side consumer (branch B) without head-of-line stalls between them.

Parameters:
- WIDTH, 32: data width of input and both outputs.
- DEPTH, 2: entries per branch FIFO; must be a power of two and at least 2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- resetn, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input word present.
- in_ready, output, 1: block accepts the input word this cycle.
- in_sel, input, 1: routing select; 0 routes to branch A, 1 routes to branch B.
- in_data, input, WIDTH: input word.
- a_valid, output, 1: branch A head entry valid.
- a_ready, input, 1: branch A consumer takes the head entry.
- a_data, output, WIDTH: branch A head entry.
- b_valid, output, 1: branch B head entry valid.
- b_ready, input, 1: branch B consumer takes the head entry.
- b_data, output, WIDTH: branch B head entry.
- a_count, output, clog2(DEPTH)+1: branch A occupancy.
- b_count, output, clog2(DEPTH)+1: branch B occupancy.

Behaviour:
- Reset (resetn low, asynchronous):
  - All pointers and counts clear to 0.
  - a_valid = b_valid = 0.
  - All FIFO storage clears to 0, so a_data = b_data = 0.
  - in_ready reflects the empty FIFOs, i.e. in_ready = 1 while in reset.
- Reset asserted mid-operation discards every stored word immediately; nothing is replayed after release.
- Handshakes:
  - Input transfer when in_valid && in_ready on a rising edge.
  - Branch A transfer when a_valid && a_ready; branch B likewise with b_valid && b_ready.
- in_ready:
  - in_ready = in_sel ? !b_full : !a_full.
  - Combinational on in_sel and the registered full flags only; no path from a_ready/b_ready or in_valid.
  - A full branch does not block the other branch: in_sel selecting the non-full branch gives in_ready = 1.
- in_sel and in_data are sampled only on an input transfer. The block places no requirement on the source holding them while stalled.
- Each branch FIFO:
  - Circular buffer with rd/wr pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - count runs 0..DEPTH; full = (count == DEPTH); valid = (count != 0); data = storage[rd_ptr].
  - Push only when the input transfers with in_sel selecting this branch; pop only on this branch's output transfer.
  - Push and pop in the same cycle: both pointers advance and count is unchanged.
  - No push is possible when full, because in_ready is 0 for that branch.
  - Pop and push to the other branch in the same cycle are independent.
- Latency:
  - A word accepted at edge N appears on x_valid/x_data after edge N.
  - This is 1 cycle when the branch was empty; otherwise the word waits behind older entries.
  - No combinational in-to-out pass-through.
- Ordering: words are strictly FIFO within a branch. Relative order between branches is not preserved.
- x_data holds stable while x_valid && !x_ready; a word is never duplicated or dropped.
- Throughput: one input transfer per cycle sustained while the selected branch drains at one word per cycle.

Test Plan:
1. Reset: assert resetn=0 mid-traffic with 2 words in A. Required: a_valid=b_valid=0, a_count=0, a_data=0, in_ready=1 asynchronously, before the next edge.
2. Single route: push 0xDEADBEEF with in_sel=0 at edge N. Required: a_valid=1 and a_data=0xDEADBEEF after edge N; b_valid stays 0; a_count=1.
3. Fill and isolate: hold a_ready=0 and push 0x11, 0x22 to A. Required:
   - With in_sel=0: a_count=2 and in_ready=0.
   - With in_sel=1: in_ready=1; push 0x33 to B, then b_data=0x33.
   - With a_ready=1: A drains 0x11 then 0x22 in order.
4. Simultaneous push/pop: A holds 1 entry, a_ready=1, push to A every cycle for 10 cycles with data 1..10. Required: a_count constant at 1, output sequence in order, pointers wrap cleanly.
5. Interleave: alternate in_sel 0,1,0,1 with data 0xA0,0xB0,0xA1,0xB1, both readys=1. Required: A emits 0xA0,0xA1; B emits 0xB0,0xB1; each word appears 1 cycle after acceptance.
6. Backpressure hold: b_ready=0 for 5 cycles with b_valid=1. Required: b_data and b_count are unchanged across all 5 cycles.
